// File: rtl/ahb2apb_bridge_pkg.sv
// Shared definitions for the AHB-Lite to APB2 bridge:
// FSM state encodings and AHB protocol codes.
package ahb2apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb2apb_bridge_psel_dec.sv
// APB slot select decoder: 4-bit index plus enable to 16-bit one-hot.
// Inverse of the read-mux select encoding in the APB subsystem.
module ahb2apb_bridge_psel_dec (
    input  logic [3:0]  i_idx,
    input  logic        i_en,
    output logic [15:0] o_sel
);

    always_comb begin
        o_sel = 16'h0000;
        if (i_en) begin
            o_sel[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave converting single transfers into APB2 accesses
// on a 16-slot peripheral bus; all outputs registered.
module ahb2apb_bridge
    import ahb2apb_bridge_pkg::*;
#(
    parameter int SLOT_LSB = 12,
    parameter int ADDR_W   = 32
) (
    input  logic              PCLK,
    input  logic              PRST,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic [ADDR_W-1:0] PADDR,
    output logic [15:0]       PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA
);

    state_t              r_state;
    logic [3:0]          r_slot;
    logic [ADDR_W-1:0]   r_haddr;
    logic                r_hreadyout;
    logic                r_hresp;
    logic [31:0]         r_hrdata;
    logic [ADDR_W-1:0]   r_paddr;
    logic [15:0]         r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [31:0]         r_pwdata;

    logic                w_idle_like;
    logic                w_acc;
    logic                w_err;
    logic [3:0]          w_addr_slot;
    logic [3:0]          w_dec_idx;
    logic [15:0]         w_psel_oh;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE)
                      || (r_state == ST_ERR2);
    assign w_acc       = HSEL & HTRANS[1] & HREADY & w_idle_like;
    assign w_err       = (HSIZE != HSIZE_WORD) | (HADDR[1:0] != 2'b00);
    assign w_addr_slot = HADDR[SLOT_LSB+3:SLOT_LSB];
    // Writes decode the slot latched in the address phase; reads decode live.
    assign w_dec_idx   = (r_state == ST_WDATA) ? r_slot : w_addr_slot;

    ahb2apb_bridge_psel_dec u_psel_dec (
        .i_idx (w_dec_idx),
        .i_en  (1'b1),
        .o_sel (w_psel_oh)
    );

    always_ff @(posedge PCLK or posedge PRST) begin
        if (PRST) begin
            r_state     <= ST_IDLE;
            r_slot      <= 4'd0;
            r_haddr     <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_hrdata    <= 32'd0;
            r_paddr     <= '0;
            r_psel      <= 16'h0000;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= 32'd0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    r_psel    <= 16'h0000;
                    r_penable <= 1'b0;
                    if (w_acc && w_err) begin
                        r_state     <= ST_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= HRESP_ERROR;
                    end else if (w_acc && HWRITE) begin
                        r_state     <= ST_WDATA;
                        r_slot      <= w_addr_slot;
                        r_haddr     <= HADDR;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= HRESP_OKAY;
                    end else if (w_acc) begin
                        r_state     <= ST_SETUP;
                        r_slot      <= w_addr_slot;
                        r_paddr     <= HADDR;
                        r_pwrite    <= 1'b0;
                        r_psel      <= w_psel_oh;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= HRESP_OKAY;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
                ST_WDATA: begin
                    r_state  <= ST_SETUP;
                    r_pwdata <= HWDATA;
                    r_paddr  <= r_haddr;
                    r_pwrite <= 1'b1;
                    r_psel   <= w_psel_oh;
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    r_state     <= ST_DONE;
                    r_psel      <= 16'h0000;
                    r_penable   <= 1'b0;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                    if (!r_pwrite) begin
                        r_hrdata <= PRDATA;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_psel      <= 16'h0000;
                    r_penable   <= 1'b0;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign HRDATA    = r_hrdata;
    assign PADDR     = r_paddr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed self-checking bench for ahb2apb_bridge.
// Each task drives one scenario and checks outputs inline.
module tb_ahb2apb_bridge;

    logic        PCLK;
    logic        PRST;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] PADDR;
    logic [15:0] PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;

    int checks;
    int failures;

    ahb2apb_bridge #(.SLOT_LSB(12), .ADDR_W(32)) dut (
        .PCLK      (PCLK),
        .PRST      (PRST),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w,
                              input logic [2:0] sz);
        HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = w; HSIZE = sz;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic test_reset();
        PRST = 1'b1;
        #3;
        checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL rst_hreadyout got=%b exp=1", HREADYOUT); end
        checks++; if (HRESP !== 1'b0) begin failures++; $display("FAIL rst_hresp got=%b exp=0", HRESP); end
        checks++; if (HRDATA !== 32'h0) begin failures++; $display("FAIL rst_hrdata got=%h exp=0", HRDATA); end
        checks++; if (PSEL !== 16'h0) begin failures++; $display("FAIL rst_psel got=%h exp=0", PSEL); end
        checks++; if (PENABLE !== 1'b0) begin failures++; $display("FAIL rst_penable got=%b exp=0", PENABLE); end
        checks++; if (PWRITE !== 1'b0) begin failures++; $display("FAIL rst_pwrite got=%b exp=0", PWRITE); end
        checks++; if (PADDR !== 32'h0) begin failures++; $display("FAIL rst_paddr got=%h exp=0", PADDR); end
        checks++; if (PWDATA !== 32'h0) begin failures++; $display("FAIL rst_pwdata got=%h exp=0", PWDATA); end
        cyc();
        @(negedge PCLK);
        PRST = 1'b0;
        cyc();
    endtask

    task automatic test_read();
        PRDATA = 32'hDEADBEEF;
        addr_phase(32'h0000_3010, 1'b0, 3'b010);
        cyc();
        bus_idle();
        checks++; if (PSEL !== 16'h0008) begin failures++; $display("FAIL rd_setup_psel got=%h exp=0008", PSEL); end
        checks++; if (PADDR !== 32'h3010) begin failures++; $display("FAIL rd_setup_paddr got=%h exp=3010", PADDR); end
        checks++; if (PENABLE !== 1'b0 || PWRITE !== 1'b0) begin failures++; $display("FAIL rd_setup_ctl got=%b%b exp=00", PENABLE, PWRITE); end
        checks++; if (HREADYOUT !== 1'b0) begin failures++; $display("FAIL rd_setup_hready got=%b exp=0", HREADYOUT); end
        cyc();
        checks++; if (PSEL !== 16'h0008 || PENABLE !== 1'b1) begin failures++; $display("FAIL rd_access got=%h/%b exp=0008/1", PSEL, PENABLE); end
        checks++; if (HREADYOUT !== 1'b0) begin failures++; $display("FAIL rd_access_hready got=%b exp=0", HREADYOUT); end
        cyc();
        checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin failures++; $display("FAIL rd_done_resp got=%b%b exp=10", HREADYOUT, HRESP); end
        checks++; if (HRDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_done_hrdata got=%h exp=deadbeef", HRDATA); end
        checks++; if (PSEL !== 16'h0 || PENABLE !== 1'b0) begin failures++; $display("FAIL rd_done_psel got=%h/%b exp=0000/0", PSEL, PENABLE); end
        cyc();
    endtask

    task automatic test_write();
        addr_phase(32'h0000_F004, 1'b1, 3'b010);
        cyc();
        bus_idle();
        HWDATA = 32'h1234_5678;
        checks++; if (HREADYOUT !== 1'b0 || PSEL !== 16'h0) begin failures++; $display("FAIL wr_wdata got=%b/%h exp=0/0000", HREADYOUT, PSEL); end
        cyc();
        HWDATA = 32'hFFFF_0000;
        checks++; if (PSEL !== 16'h8000 || PENABLE !== 1'b0) begin failures++; $display("FAIL wr_setup_psel got=%h/%b exp=8000/0", PSEL, PENABLE); end
        checks++; if (PWRITE !== 1'b1 || PWDATA !== 32'h12345678) begin failures++; $display("FAIL wr_setup_data got=%b/%h exp=1/12345678", PWRITE, PWDATA); end
        checks++; if (PADDR !== 32'hF004 || HREADYOUT !== 1'b0) begin failures++; $display("FAIL wr_setup_addr got=%h/%b exp=f004/0", PADDR, HREADYOUT); end
        cyc();
        checks++; if (PSEL !== 16'h8000 || PENABLE !== 1'b1 || HREADYOUT !== 1'b0) begin failures++; $display("FAIL wr_access got=%h/%b/%b exp=8000/1/0", PSEL, PENABLE, HREADYOUT); end
        checks++; if (PWDATA !== 32'h12345678) begin failures++; $display("FAIL wr_access_pwdata got=%h exp=12345678", PWDATA); end
        cyc();
        checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PSEL !== 16'h0) begin failures++; $display("FAIL wr_done got=%b/%b/%h exp=1/0/0000", HREADYOUT, HRESP, PSEL); end
        checks++; if (HRDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_hrdata_hold got=%h exp=deadbeef", HRDATA); end
        cyc();
    endtask

    task automatic test_back_to_back();
        PRDATA = 32'hA5A5_0001;
        addr_phase(32'h0000_0020, 1'b0, 3'b010);
        cyc();
        bus_idle();
        checks++; if (PSEL !== 16'h0001) begin failures++; $display("FAIL b2b_setup_psel got=%h exp=0001", PSEL); end
        cyc();
        checks++; if (PSEL !== 16'h0001 || PENABLE !== 1'b1) begin failures++; $display("FAIL b2b_access got=%h/%b exp=0001/1", PSEL, PENABLE); end
        cyc();
        checks++; if (PSEL !== 16'h0 || HREADYOUT !== 1'b1) begin failures++; $display("FAIL b2b_done got=%h/%b exp=0000/1", PSEL, HREADYOUT); end
        checks++; if (HRDATA !== 32'hA5A50001) begin failures++; $display("FAIL b2b_hrdata got=%h exp=a5a50001", HRDATA); end
        addr_phase(32'h0000_5008, 1'b1, 3'b010);
        cyc();
        bus_idle();
        HWDATA = 32'hCAFE_F00D;
        checks++; if (HREADYOUT !== 1'b0 || PSEL !== 16'h0) begin failures++; $display("FAIL b2b_wdata got=%b/%h exp=0/0000", HREADYOUT, PSEL); end
        cyc();
        checks++; if (PSEL !== 16'h0020 || PADDR !== 32'h5008) begin failures++; $display("FAIL b2b_wr_setup got=%h/%h exp=0020/5008", PSEL, PADDR); end
        checks++; if (PWDATA !== 32'hCAFEF00D || PWRITE !== 1'b1) begin failures++; $display("FAIL b2b_wr_data got=%h/%b exp=cafef00d/1", PWDATA, PWRITE); end
        cyc();
        cyc();
        checks++; if (HREADYOUT !== 1'b1 || PSEL !== 16'h0 || HRDATA !== 32'hA5A50001) begin failures++; $display("FAIL b2b_wr_done got=%b/%h/%h exp=1/0000/a5a50001", HREADYOUT, PSEL, HRDATA); end
        cyc();
    endtask

    task automatic test_errors();
        PRDATA = 32'h5555_AAAA;
        addr_phase(32'h0000_1000, 1'b0, 3'b001);
        cyc();
        bus_idle();
        checks++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin failures++; $display("FAIL err_sz_e1 got=%b%b exp=01", HREADYOUT, HRESP); end
        checks++; if (PSEL !== 16'h0 || PENABLE !== 1'b0) begin failures++; $display("FAIL err_sz_e1_apb got=%h/%b exp=0000/0", PSEL, PENABLE); end
        cyc();
        checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || PSEL !== 16'h0) begin failures++; $display("FAIL err_sz_e2 got=%b%b/%h exp=11/0000", HREADYOUT, HRESP, PSEL); end
        addr_phase(32'h0000_2002, 1'b0, 3'b010);
        cyc();
        bus_idle();
        checks++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || PSEL !== 16'h0) begin failures++; $display("FAIL err_al_e1 got=%b%b/%h exp=01/0000", HREADYOUT, HRESP, PSEL); end
        cyc();
        checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || PSEL !== 16'h0) begin failures++; $display("FAIL err_al_e2 got=%b%b/%h exp=11/0000", HREADYOUT, HRESP, PSEL); end
        cyc();
        checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin failures++; $display("FAIL err_idle got=%b%b exp=10", HREADYOUT, HRESP); end
        checks++; if (HRDATA !== 32'hA5A50001 || PADDR !== 32'h5008) begin failures++; $display("FAIL err_hold got=%h/%h exp=a5a50001/5008", HRDATA, PADDR); end
    endtask

    task automatic test_filter();
        logic [3:0] vec [3];
        vec[0] = 4'b1_01_1;
        vec[1] = 4'b0_10_1;
        vec[2] = 4'b1_10_0;
        for (int i = 0; i < 3; i++) begin
            HSEL = vec[i][3]; HTRANS = vec[i][2:1]; HREADY = vec[i][0];
            HADDR = 32'h0000_4000; HWRITE = 1'b0; HSIZE = 3'b010;
            cyc();
            bus_idle();
            HREADY = 1'b1;
            checks++; if (HREADYOUT !== 1'b1 || PSEL !== 16'h0 || HRESP !== 1'b0) begin failures++; $display("FAIL filt%0d_a got=%b/%h/%b exp=1/0000/0", i, HREADYOUT, PSEL, HRESP); end
            cyc();
            checks++; if (HREADYOUT !== 1'b1 || PSEL !== 16'h0) begin failures++; $display("FAIL filt%0d_b got=%b/%h exp=1/0000", i, HREADYOUT, PSEL); end
        end
    endtask

    task automatic test_reset_mid_access();
        PRDATA = 32'h1111_2222;
        addr_phase(32'h0000_7000, 1'b0, 3'b010);
        cyc();
        bus_idle();
        cyc();
        checks++; if (PENABLE !== 1'b1 || PSEL !== 16'h0080) begin failures++; $display("FAIL rma_access got=%b/%h exp=1/0080", PENABLE, PSEL); end
        #2;
        PRST = 1'b1;
        #1;
        checks++; if (PSEL !== 16'h0 || PENABLE !== 1'b0) begin failures++; $display("FAIL rma_apb got=%h/%b exp=0000/0", PSEL, PENABLE); end
        checks++; if (HRDATA !== 32'h0 || HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin failures++; $display("FAIL rma_ahb got=%h/%b/%b exp=0/0/1", HRDATA, HRESP, HREADYOUT); end
        @(negedge PCLK);
        PRST = 1'b0;
        cyc();
        PRDATA = 32'h3333_4444;
        addr_phase(32'h0000_9000, 1'b0, 3'b010);
        cyc();
        bus_idle();
        checks++; if (PSEL !== 16'h0200 || PADDR !== 32'h9000) begin failures++; $display("FAIL rma_new_setup got=%h/%h exp=0200/9000", PSEL, PADDR); end
        cyc();
        cyc();
        checks++; if (HRDATA !== 32'h33334444 || HREADYOUT !== 1'b1) begin failures++; $display("FAIL rma_new_done got=%h/%b exp=33334444/1", HRDATA, HREADYOUT); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        PRST = 1'b1;
        HSEL = 1'b0;
        HADDR = 32'h0;
        HTRANS = 2'b00;
        HSIZE = 3'b010;
        HWRITE = 1'b0;
        HWDATA = 32'h0;
        HREADY = 1'b1;
        PRDATA = 32'h0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_errors();
        test_filter();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
